stack_controller: RTL and testbench

Multicycle control unit for the 8-bit stack-machine CPU. Consumes the 3-bit `opcode` presented by the datapath's instruction register and sequences every datapath control strobe (PC, memory, IR, stack, A/B, ALU selects) one state per clock. Sits beside the datapath at CPU top level and is the other end of its control interface. Also exposes an instruction-retire pulse and counter for bench checking.

---
 rtl/stack_ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_out_decode.sv | 89 ++++++++
 rtl/stack_controller.sv | 142 ++++++++++++++
 tb/tb_stack_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stack_ctrl_pkg
// Description : Shared definitions for the stack-machine control unit:
//               opcode values, ALU operation selects, FSM state encoding and
//               the packed control word driven to the datapath.
// Revision    : 1.0  initial release
// ============================================================================
package stack_ctrl_pkg;

    // Instruction opcodes as found in IR[7:5]
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    // ALU operation selects
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // FSM state encoding (codes 13-15 are unused and recover to START)
    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_POP_A  = 4'd3,
        ST_POP_B  = 4'd4,
        ST_EXEC   = 4'd5,
        ST_WB_ALU = 4'd6,
        ST_MEM_RD = 4'd7,
        ST_WB_MEM = 4'd8,
        ST_MEM_WR = 4'd9,
        ST_JUMP   = 4'd10,
        ST_JZ_TOS = 4'd11,
        ST_JZ_BR  = 4'd12
    } state_e;

    // Control word: every datapath strobe/select plus the retire pulse
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_src;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       m_to_s;
        logic       ld_a;
        logic       ld_b;
        logic       src_a;
        logic       src_b;
        logic       push;
        logic       pop;
        logic       tos;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage : stack_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_out_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_out_decode
// Description : Moore output decoder for the stack-machine control unit.
//               Maps the current FSM state (and, in EXEC, the latched ALU
//               select) to the full datapath control word.
// Ports       : state   - current FSM state
//               alu_sel - op_q[1:0], latched opcode low bits (ALU function)
//               ctrl    - decoded control word
// Revision    : 1.0  initial release
// ============================================================================
module ctrl_out_decode
    import stack_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [1:0] alu_sel,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                // IR <- mem[PC] while the ALU computes PC + 1
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.src_a     = 1'b1;
                ctrl.src_b     = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_src    = 1'b0;
            end
            ST_POP_A: begin
                ctrl.tos  = 1'b1;
                ctrl.pop  = 1'b1;
                ctrl.ld_a = 1'b1;
            end
            ST_POP_B: begin
                ctrl.tos  = 1'b1;
                ctrl.pop  = 1'b1;
                ctrl.ld_b = 1'b1;
            end
            ST_EXEC: begin
                // ALU function comes straight from the opcode low bits
                ctrl.src_a  = 1'b0;
                ctrl.src_b  = 1'b0;
                ctrl.alu_op = alu_sel;
            end
            ST_WB_ALU: begin
                ctrl.m_to_s     = 1'b0;
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.m_to_s     = 1'b1;
                ctrl.push       = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JZ_TOS: begin
                // Zero flag samples the top of stack; the stack is not popped
                ctrl.tos = 1'b1;
            end
            ST_JZ_BR: begin
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule : ctrl_out_decode
`default_nettype wire

// File: rtl/stack_controller.sv
`default_nettype none
// ============================================================================
// Module      : stack_controller
// Description : Multicycle control unit for the 8-bit stack-machine CPU.
//               Sequences the datapath one state per clock from the opcode
//               in the instruction register, and counts retired instructions.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               opcode            - IR[7:5] from the datapath
//               pcWrite..tos      - datapath strobes and selects
//               ALUOp             - 00 add, 01 sub, 10 and, 11 not(A)
//               instr_done        - one-cycle pulse in each final state
//               instr_count       - instructions retired since reset
//               state             - current FSM state (debug)
// Revision    : 1.0  initial release
// ============================================================================
module stack_controller
    import stack_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             pcSrc,
    output logic             IorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             IRWrite,
    output logic             MtoS,
    output logic             ldA,
    output logic             ldB,
    output logic             srcA,
    output logic             srcB,
    output logic             push,
    output logic             pop,
    output logic             tos,
    output logic [1:0]       ALUOp,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl_word;

    // ------------------------------------------------------------------
    // State, latched opcode and retire counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_START;
            op_q    <= OP_ADD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            // Later states branch on this copy so a changing IR cannot
            // redirect an instruction already in flight.
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
            if (ctrl_word.instr_done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_START;
        case (state_q)
            ST_START:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                // Only state that looks at the live opcode
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = ST_POP_A;
                    OP_PUSH:                        state_d = ST_MEM_RD;
                    OP_POP:                         state_d = ST_POP_A;
                    OP_JMP:                         state_d = ST_JUMP;
                    OP_JZ:                          state_d = ST_JZ_TOS;
                    default:                        state_d = ST_START;
                endcase
            end
            ST_POP_A: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND: state_d = ST_POP_B;
                    OP_NOT:                 state_d = ST_EXEC;
                    OP_POP:                 state_d = ST_MEM_WR;
                    default:                state_d = ST_START;
                endcase
            end
            ST_POP_B:  state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB_ALU;
            ST_WB_ALU: state_d = ST_FETCH;
            ST_MEM_RD: state_d = ST_WB_MEM;
            ST_WB_MEM: state_d = ST_FETCH;
            ST_MEM_WR: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_JZ_TOS: state_d = ST_JZ_BR;
            ST_JZ_BR:  state_d = ST_FETCH;
            default:   state_d = ST_START;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    ctrl_out_decode u_ctrl_out_decode (
        .state   (state_q),
        .alu_sel (op_q[1:0]),
        .ctrl    (ctrl_word)
    );

    assign pcWrite     = ctrl_word.pc_write;
    assign pcWriteCond = ctrl_word.pc_write_cond;
    assign pcSrc       = ctrl_word.pc_src;
    assign IorD        = ctrl_word.i_or_d;
    assign memRead     = ctrl_word.mem_read;
    assign memWrite    = ctrl_word.mem_write;
    assign IRWrite     = ctrl_word.ir_write;
    assign MtoS        = ctrl_word.m_to_s;
    assign ldA         = ctrl_word.ld_a;
    assign ldB         = ctrl_word.ld_b;
    assign srcA        = ctrl_word.src_a;
    assign srcB        = ctrl_word.src_b;
    assign push        = ctrl_word.push;
    assign pop         = ctrl_word.pop;
    assign tos         = ctrl_word.tos;
    assign ALUOp       = ctrl_word.alu_op;
    assign instr_done  = ctrl_word.instr_done;
    assign instr_count = count_q;
    assign state       = state_q;

endmodule : stack_controller
`default_nettype wire

// File: tb/tb_stack_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_controller
// Description : Scoreboard bench for stack_controller. The stimulus process
//               pushes the hand-derived per-cycle expectation for each
//               instruction; the monitor pops one entry per clock and
//               compares state, control word, retire pulse and counters.
//               A second instance with CNT_W=4 shares all inputs so the
//               counter wrap can be observed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stack_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;

    always #5 clk = ~clk;

    // Main instance outputs
    logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic ldA, ldB, srcA, srcB, push, pop, tos, instr_done;
    logic [1:0]  ALUOp;
    logic [15:0] instr_count;
    logic [3:0]  state;

    // Narrow-counter instance outputs
    logic n_pcWrite, n_pcWriteCond, n_pcSrc, n_IorD, n_memRead, n_memWrite;
    logic n_IRWrite, n_MtoS, n_ldA, n_ldB, n_srcA, n_srcB, n_push, n_pop;
    logic n_tos, n_instr_done;
    logic [1:0] n_ALUOp;
    logic [3:0] n_instr_count;
    logic [3:0] n_state;

    stack_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc),
        .IorD(IorD), .memRead(memRead), .memWrite(memWrite),
        .IRWrite(IRWrite), .MtoS(MtoS), .ldA(ldA), .ldB(ldB),
        .srcA(srcA), .srcB(srcB), .push(push), .pop(pop), .tos(tos),
        .ALUOp(ALUOp), .instr_done(instr_done),
        .instr_count(instr_count), .state(state)
    );

    stack_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode),
        .pcWrite(n_pcWrite), .pcWriteCond(n_pcWriteCond), .pcSrc(n_pcSrc),
        .IorD(n_IorD), .memRead(n_memRead), .memWrite(n_memWrite),
        .IRWrite(n_IRWrite), .MtoS(n_MtoS), .ldA(n_ldA), .ldB(n_ldB),
        .srcA(n_srcA), .srcB(n_srcB), .push(n_push), .pop(n_pop), .tos(n_tos),
        .ALUOp(n_ALUOp), .instr_done(n_instr_done),
        .instr_count(n_instr_count), .state(n_state)
    );

    // Control-word bit masks:
    // {pcWrite,pcWriteCond,pcSrc,IorD,memRead,memWrite,IRWrite,MtoS,
    //  ldA,ldB,srcA,srcB,push,pop,tos,ALUOp[1:0]}
    localparam logic [16:0] M_PCW  = 17'h1_0000;
    localparam logic [16:0] M_PCWC = 17'h0_8000;
    localparam logic [16:0] M_PSRC = 17'h0_4000;
    localparam logic [16:0] M_IORD = 17'h0_2000;
    localparam logic [16:0] M_MRD  = 17'h0_1000;
    localparam logic [16:0] M_MWR  = 17'h0_0800;
    localparam logic [16:0] M_IRW  = 17'h0_0400;
    localparam logic [16:0] M_MTOS = 17'h0_0200;
    localparam logic [16:0] M_LDA  = 17'h0_0100;
    localparam logic [16:0] M_LDB  = 17'h0_0080;
    localparam logic [16:0] M_SA   = 17'h0_0040;
    localparam logic [16:0] M_SB   = 17'h0_0020;
    localparam logic [16:0] M_PUSH = 17'h0_0010;
    localparam logic [16:0] M_POP  = 17'h0_0008;
    localparam logic [16:0] M_TOS  = 17'h0_0004;

    localparam logic [16:0] C_FETCH = M_MRD | M_IRW | M_SA | M_SB | M_PCW;
    localparam logic [16:0] C_POPA  = M_TOS | M_POP | M_LDA;
    localparam logic [16:0] C_POPB  = M_TOS | M_POP | M_LDB;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_count;
    int          vectors = 0;
    int          errors  = 0;

    task automatic push_exp(input logic [3:0] st, input logic [16:0] ctrl,
                            input logic done);
        exp_t e;
        e.st   = st;
        e.ctrl = ctrl;
        e.done = done;
        e.cnt  = exp_count;
        sb.push_back(e);
        if (done) exp_count = exp_count + 16'd1;
    endtask

    // Issue one instruction: queue its expected cycles, then let it run.
    // Optionally change the live opcode on a given cycle of the instruction.
    task automatic run_instr(input logic [2:0] op, input int chg_at,
                             input logic [2:0] chg_op);
        int n;
        n = 0;
        opcode = op;
        push_exp(4'd1, C_FETCH, 1'b0); n++;
        push_exp(4'd2, 17'h0, 1'b0);   n++;
        case (op)
            3'b000, 3'b001, 3'b010: begin
                push_exp(4'd3, C_POPA, 1'b0);              n++;
                push_exp(4'd4, C_POPB, 1'b0);              n++;
                push_exp(4'd5, {15'h0, op[1:0]}, 1'b0);    n++;
                push_exp(4'd6, M_PUSH, 1'b1);              n++;
            end
            3'b011: begin
                push_exp(4'd3, C_POPA, 1'b0);              n++;
                push_exp(4'd5, {15'h0, 2'b11}, 1'b0);      n++;
                push_exp(4'd6, M_PUSH, 1'b1);              n++;
            end
            3'b100: begin
                push_exp(4'd7, M_IORD | M_MRD, 1'b0);      n++;
                push_exp(4'd8, M_MTOS | M_PUSH, 1'b1);     n++;
            end
            3'b101: begin
                push_exp(4'd3, C_POPA, 1'b0);              n++;
                push_exp(4'd9, M_IORD | M_MWR, 1'b1);      n++;
            end
            3'b110: begin
                push_exp(4'd10, M_PSRC | M_PCW, 1'b1);     n++;
            end
            default: begin
                push_exp(4'd11, M_TOS, 1'b0);              n++;
                push_exp(4'd12, M_PSRC | M_PCWC, 1'b1);    n++;
            end
        endcase
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == chg_at) opcode = chg_op;
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: one expectation per clock, sampled 1 time unit after the edge
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t        e;
        logic [16:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite,
                       IRWrite, MtoS, ldA, ldB, srcA, srcB, push, pop, tos,
                       ALUOp};
                vectors++;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state @%0t: got %0d expected %0d", $time, state, e.st);
                end
                if (act !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl @%0t state %0d: got %05h expected %05h",
                             $time, e.st, act, e.ctrl);
                end
                if (instr_done !== e.done) begin
                    errors++;
                    $display("FAIL instr_done @%0t: got %b expected %b", $time, instr_done, e.done);
                end
                if (instr_count !== e.cnt) begin
                    errors++;
                    $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, e.cnt);
                end
                if (n_instr_count !== e.cnt[3:0]) begin
                    errors++;
                    $display("FAIL instr_count_w4 @%0t: got %0d expected %0d",
                             $time, n_instr_count, e.cnt[3:0]);
                end
                if ((push && pop) || (memRead && memWrite) || (pcWrite && pcWriteCond)) begin
                    errors++;
                    $display("FAIL exclusive_strobes @%0t: got ctrl %05h", $time, act);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stimulus
        rst       = 1'b1;
        opcode    = 3'b000;
        exp_count = 16'd0;

        // Three reset cycles: START, everything low, counter zero
        repeat (3) push_exp(4'd0, 17'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADD aborted by reset while in EXEC: back to START, nothing retired
        opcode = 3'b000;
        push_exp(4'd1, C_FETCH, 1'b0);
        push_exp(4'd2, 17'h0, 1'b0);
        push_exp(4'd3, C_POPA, 1'b0);
        push_exp(4'd4, C_POPB, 1'b0);
        push_exp(4'd5, 17'h0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        push_exp(4'd0, 17'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(3'b000, 0, 3'b000);   // ADD
        run_instr(3'b001, 0, 3'b000);   // SUB
        run_instr(3'b010, 0, 3'b000);   // AND
        run_instr(3'b011, 0, 3'b000);   // NOT
        run_instr(3'b100, 0, 3'b000);   // PUSH
        run_instr(3'b101, 0, 3'b000);   // POP
        run_instr(3'b110, 0, 3'b000);   // JMP
        run_instr(3'b111, 0, 3'b000);   // JZ
        // ADD whose IR changes to JMP after decode: path must not change
        run_instr(3'b000, 3, 3'b110);
        // Enough JMPs to carry the 4-bit counter through its wrap
        repeat (16) run_instr(3'b110, 0, 3'b000);

        begin : drain
            int budget;
            budget = 20;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
        end
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_stack_controller
`default_nettype wire
